// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA frame-buffer arbiter.
//   H_ACTIVE/V_ACTIVE : visible screen size in screen pixels
//   FB_W/FB_H/FB_SIZE : frame-buffer geometry (one fb pixel = 4x4 screen pixels)
//   ADDR_W/DATA_W     : frame-buffer address and colour word widths
//   PIX_SHIFT         : screen-to-fb coordinate shift (divide by 4)
//   slot_e            : position of the current clock within a pixel period
package vga_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int FB_W      = 160;
    localparam int FB_H      = 120;
    localparam int FB_SIZE   = FB_W * FB_H;
    localparam int ADDR_W    = 15;
    localparam int DATA_W    = 8;
    localparam int PIX_SHIFT = 2;

    typedef enum logic [1:0] {
        SLOT_DISP = 2'd0,
        SLOT_W1   = 2'd1,
        SLOT_W2   = 2'd2,
        SLOT_W3   = 2'd3
    } slot_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter with an enable.
//   clk_i, rst_ni : clock and asynchronous active-low reset
//   en_i          : grants are only issued while high
//   req_i[1:0]    : request vector (bit n = requester n)
//   gnt_o[1:0]    : one-hot (or zero) grant, combinational from req_i
// The pointer remembers who was granted last; after reset it says
// "requester 1", so requester 0 wins the first contention.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
        // Pointer moves only when somebody actually gets the slot.
        if (gnt_o != 2'b00) begin
            last_d = gnt_o[1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Time-slot scheduler for a single-port frame buffer shared by VGA
// scan-out and two pixel writers. The clock runs at 4x the pixel rate;
// the pix_tick cycle is slot 0 and belongs to display fetch during
// active video, every other cycle is a writer slot.
//   clock, reset_n        : system clock, asynchronous active-low reset
//   pix_tick, video       : slot-0 marker and active-area flag
//   hcount, vcount        : screen coordinates of the pixel being fetched
//   reqN/addrN/wdataN     : writer request, held until gntN
//   gntN                  : one-cycle grant, write issued in the same cycle
//   mem_en/we/addr/wdata  : frame-buffer port (combinational)
//   mem_rdata             : read data, one cycle after a read
//   pix_color             : registered colour for the display path
//   err                   : sticky flag, out-of-range write attempted
module vga_fb_arbiter
    import vga_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pix_tick,
    input  logic              video,
    input  logic [9:0]        hcount,
    input  logic [9:0]        vcount,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_color,
    output logic              err
);

    slot_e             slot_q, slot_d, cur_slot;
    logic              rd_pend_q, rd_pend_d;
    logic [DATA_W-1:0] pix_color_q, pix_color_d;
    logic              err_q, err_d;

    logic              disp;
    logic              blank_tick;
    logic              arb_en;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_in_range;

    // Slot counter: loads W1 after a tick and saturates at W3, so if ticks
    // stop every cycle is a writer slot. The counter never holds SLOT_DISP,
    // so only the tick itself can select the display slot.
    always_comb begin
        cur_slot = pix_tick ? SLOT_DISP : slot_q;
        if (pix_tick) begin
            slot_d = SLOT_W1;
        end else if (slot_q == SLOT_W3) begin
            slot_d = SLOT_W3;
        end else begin
            slot_d = slot_e'(slot_q + 2'd1);
        end
    end

    // Outputs are gated with reset_n so nothing is issued while held in reset.
    assign disp       = reset_n && (cur_slot == SLOT_DISP) && video;
    assign blank_tick = (cur_slot == SLOT_DISP) && !video;
    assign arb_en     = reset_n && !disp;

    rr_arbiter2 u_arb (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .en_i   (arb_en),
        .req_i  ({req1, req0}),
        .gnt_o  (gnt)
    );

    assign gnt0 = gnt[0];
    assign gnt1 = gnt[1];

    // Screen -> fb coordinate, full-width arithmetic then truncated.
    assign disp_addr = ADDR_W'(32'(vcount >> PIX_SHIFT) * 32'(FB_W)
                              + 32'(hcount >> PIX_SHIFT));

    assign wr_addr     = gnt[1] ? addr1  : addr0;
    assign wr_data     = gnt[1] ? wdata1 : wdata0;
    assign wr_in_range = 32'(wr_addr) < 32'(FB_SIZE);

    // An out-of-range write is still granted (so the writer moves on) but
    // the port stays idle for that cycle.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (disp) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end else if ((gnt != 2'b00) && wr_in_range) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end
    end

    always_comb begin
        rd_pend_d   = disp;
        err_d       = err_q | ((gnt != 2'b00) && !wr_in_range);
        pix_color_d = pix_color_q;
        if (rd_pend_q) begin
            pix_color_d = mem_rdata;
        end
        // A blanking tick is the newer event, so it wins over a late capture.
        if (blank_tick) begin
            pix_color_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_q      <= SLOT_W3;
            rd_pend_q   <= 1'b0;
            pix_color_q <= '0;
            err_q       <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            rd_pend_q   <= rd_pend_d;
            pix_color_q <= pix_color_d;
            err_q       <= err_d;
        end
    end

    assign pix_color = pix_color_q;
    assign err       = err_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

    localparam int FB_SIZE = 19200;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        pix_tick = 1'b0;
    logic        video = 1'b0;
    logic [9:0]  hcount = '0;
    logic [9:0]  vcount = '0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [14:0] addr0 = '0, addr1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, mem_en, mem_we;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  pix_color;
    logic        err;

    vga_fb_arbiter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .pix_tick  (pix_tick),
        .video     (video),
        .hcount    (hcount),
        .vcount    (vcount),
        .req0      (req0),
        .req1      (req1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .pix_color (pix_color),
        .err       (err)
    );

    always #5 clock = ~clock;

    // Frame-buffer stand-in: registered read, garbage on cycles without a read.
    logic [7:0] fb_mem [FB_SIZE];
    logic       mem_clr = 1'b1;
    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < FB_SIZE; i++) fb_mem[i] <= 8'h00;
        end else if (mem_en && mem_we && (int'(mem_addr) < FB_SIZE)) begin
            fb_mem[mem_addr] <= mem_wdata;
        end
        if (mem_en && !mem_we && (int'(mem_addr) < FB_SIZE)) mem_rdata <= fb_mem[mem_addr];
        else mem_rdata <= 8'($urandom);
    end

    // Reference model: expected frame contents plus arbiter/display state.
    logic [7:0] ref_fb [FB_SIZE];
    int         m_last;        // requester granted most recently
    bit         m_err;
    logic [7:0] m_pix;
    bit         m_pend;
    logic [7:0] m_pend_val;    // value the pending display read will return

    int n_checks = 0;
    int n_pass   = 0;
    int n_gnt    = 0;
    bit g0_seen  = 0, g1_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        m_last = 1;
        m_err  = 0;
        m_pix  = 8'h00;
        m_pend = 0;
        m_pend_val = 8'h00;
    endtask

    // One clock: inputs are already driven; check at the falling edge,
    // then advance the model across the rising edge.
    task automatic step();
        bit         e_g0, e_g1, e_en, e_we, disp, inr;
        logic [14:0] e_addr, wa;
        logic [7:0]  e_wd, wd, n_pix;
        int          win, daddr;
        e_g0 = 0; e_g1 = 0; e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
        disp = 0; inr = 0; win = -1; daddr = 0; wa = '0; wd = '0;
        @(negedge clock);
        if (reset_n) begin
            disp = pix_tick && video;
            if (disp) begin
                daddr  = (int'(vcount) / 4) * 160 + int'(hcount) / 4;
                e_en   = 1;
                e_addr = 15'(daddr);
            end else begin
                if (req0 && req1) win = (m_last == 1) ? 0 : 1;
                else if (req0)    win = 0;
                else if (req1)    win = 1;
                if (win >= 0) begin
                    wa   = (win == 1) ? addr1 : addr0;
                    wd   = (win == 1) ? wdata1 : wdata0;
                    e_g0 = (win == 0);
                    e_g1 = (win == 1);
                    inr  = int'(wa) < FB_SIZE;
                    if (inr) begin
                        e_en = 1; e_we = 1; e_addr = wa; e_wd = wd;
                    end
                end
            end
        end
        check_eq("gnt0", 32'(gnt0), 32'(e_g0));
        check_eq("gnt1", 32'(gnt1), 32'(e_g1));
        check_eq("mem_en", 32'(mem_en), 32'(e_en));
        check_eq("mem_we", 32'(mem_we), 32'(e_we));
        check_eq("mem_addr", 32'(mem_addr), 32'(e_addr));
        check_eq("mem_wdata", 32'(mem_wdata), 32'(e_wd));
        check_eq("pix_color", 32'(pix_color), 32'(m_pix));
        check_eq("err", 32'(err), 32'(m_err));
        g0_seen = gnt0;
        g1_seen = gnt1;
        if (gnt0 || gnt1) n_gnt++;
        if (disp) $display("%0t disp read addr=%0d", $time, daddr);
        if (win >= 0) $display("%0t grant w%0d addr=%0d data=%02h%s", $time, win, wa, wd, inr ? "" : " (out of range)");

        n_pix = m_pix;
        if (m_pend) n_pix = m_pend_val;
        if (reset_n && pix_tick && !video) n_pix = 8'h00;
        @(posedge clock);
        #1;
        if (!reset_n) begin
            model_reset();
        end else begin
            m_pix  = n_pix;
            m_pend = disp;
            if (disp) m_pend_val = ref_fb[daddr];
            if (win >= 0) begin
                m_last = win;
                if (inr) ref_fb[wa] = wd;
                else m_err = 1;
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        step();
        step();
        reset_n = 1'b1;
    endtask

    function automatic logic [14:0] rnd_addr();
        if ($urandom_range(0, 49) == 0) return 15'($urandom_range(FB_SIZE, 32767));
        return 15'($urandom_range(0, 639));
    endfunction

    initial begin
        for (int i = 0; i < FB_SIZE; i++) ref_fb[i] = 8'h00;
        model_reset();

        // Reset held with requests and ticks active.
        req0 = 1; req1 = 1; video = 1;
        for (int i = 0; i < 8; i++) begin
            pix_tick = (i % 2 == 0);
            step();
        end
        mem_clr = 1'b0;
        req0 = 0; req1 = 0; pix_tick = 0;
        step();
        reset_n = 1'b1;
        step();

        // Display fetch of (8,4) -> fb address 162 holding 0xA5.
        video = 0; req0 = 1; addr0 = 15'd162; wdata0 = 8'hA5;
        step();
        req0 = 0;
        step();
        video = 1; hcount = 10'd8; vcount = 10'd4; pix_tick = 1;
        step();
        pix_tick = 0;
        step();
        check_eq("disp_pix", 32'(pix_color), 32'h0000_00A5);

        // Blanking tick doubles as a writer slot and clears the colour.
        step();
        video = 0; pix_tick = 1; req0 = 1; addr0 = 15'd5; wdata0 = 8'h3C;
        step();
        pix_tick = 0; req0 = 0;
        check_eq("blank_pix", 32'(pix_color), 32'h0);
        step();

        // Contention: both writers over 8 pixels of active video.
        do_reset();
        n_gnt = 0;
        video = 1; hcount = 10'd100; vcount = 10'd40;
        req0 = 1; req1 = 1;
        for (int i = 0; i < 32; i++) begin
            pix_tick = (i % 4 == 0);
            addr0 = 15'(200 + i); wdata0 = 8'(i);
            addr1 = 15'(300 + i); wdata1 = 8'(i + 128);
            step();
        end
        check_eq("grant_total", 32'(n_gnt), 32'd24);
        req0 = 0; req1 = 0; pix_tick = 0;
        step();

        // Out-of-range write: granted, suppressed, sticky error.
        do_reset();
        video = 0; req0 = 1; addr0 = 15'd19200; wdata0 = 8'h11;
        step();
        req0 = 0;
        step();
        check_eq("oor_err", 32'(err), 32'h1);
        req0 = 1; addr0 = 15'd7; wdata0 = 8'h22;
        step();
        req0 = 0;
        step();
        check_eq("oor_sticky", 32'(err), 32'h1);

        // Async reset between a display read and its capture.
        do_reset();
        req0 = 1; addr0 = 15'd0; wdata0 = 8'h5A;
        step();
        addr0 = 15'd1; wdata0 = 8'hC3;
        step();
        req0 = 0; video = 1; hcount = 10'd0; vcount = 10'd0; pix_tick = 1;
        step();
        pix_tick = 0;
        step();
        step();
        step();
        hcount = 10'd4; pix_tick = 1;
        step();
        pix_tick = 0; req0 = 1; req1 = 1; addr0 = 15'd20; addr1 = 15'd21;
        check_eq("pre_arst_pix", 32'(pix_color), 32'h5A);
        reset_n = 1'b0;
        #1;
        check_eq("arst_pix", 32'(pix_color), 32'h0);
        model_reset();
        step();
        check_eq("arst_nocap", 32'(pix_color), 32'h0);
        step();
        reset_n = 1'b1;
        video = 0;
        step();
        check_eq("post_rst_first_gnt0", 32'(g0_seen), 32'h1);
        step();
        req0 = 0; req1 = 0;
        step();

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            if (c % 200 == 199) begin
                do_reset();
            end else begin
                pix_tick = (c % 4 == 0) && ((c / 100) % 4 != 3);
                if (pix_tick) begin
                    video  = ($urandom_range(0, 3) != 0);
                    hcount = 10'($urandom_range(0, 639));
                    vcount = 10'($urandom_range(0, 15));
                end
                if (!req0 || g0_seen) begin
                    req0 = ($urandom_range(0, 2) != 0); addr0 = rnd_addr(); wdata0 = 8'($urandom);
                end
                if (!req1 || g1_seen) begin
                    req1 = ($urandom_range(0, 2) != 0); addr1 = rnd_addr(); wdata1 = 8'($urandom);
                end
                step();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
